led_position_decoder: RTL and testbench

//   Receiving end of the scanning-LED bus. Samples an OUT_WIDTH-bit LED vector
//   (one-hot, possibly PWM-gated to all-zero) and recovers the lit position, scan direction,

---
 rtl/led_position_decoder.sv | 134 +++++++++++++
 tb/tb_led_position_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/led_position_decoder.sv
// Observer for the scanning-LED bus: recovers lit position, direction, step/bounce
// events, a saturating bounce count and a sticky protocol-error flag.
module led_position_decoder #(
  parameter  int OUT_WIDTH   = 8,
  parameter  int HOLD_CYCLES = 16,
  parameter  int CNT_WIDTH   = 8,
  localparam int POS_W       = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1,
  localparam int GAP_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [OUT_WIDTH-1:0] leds_in,
  input  logic                 err_clr,
  output logic [POS_W-1:0]     pos,
  output logic                 pos_valid,
  output logic                 dir,
  output logic                 step,
  output logic                 bounce,
  output logic [CNT_WIDTH-1:0] bounce_count,
  output logic                 err,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DARK  = 2'd2
  } state_t;

  localparam logic [POS_W:0]     ONE_P    = 1;
  localparam logic [GAP_W-1:0]   ONE_G    = 1;
  localparam logic [CNT_WIDTH-1:0] ONE_C  = 1;
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(HOLD_CYCLES - 1);

  state_t               state;
  logic [OUT_WIDTH-1:0] sync1, sample;
  logic [GAP_W-1:0]     gap;
  logic                 dir_known;

  logic                 any_set, multi_set;
  logic [POS_W-1:0]     idx;
  logic                 same, up, down, jump, err_set;

  assign fsm_state = state;

  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    idx       = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (sample[i]) begin
        multi_set = multi_set | any_set;
        any_set   = 1'b1;
        idx       = POS_W'(i);
      end
    end
  end

  // Adjacency is evaluated one bit wider so pos+1 cannot wrap at the MSB.
  assign same    = (idx == pos);
  assign up      = ({1'b0, idx} == {1'b0, pos} + ONE_P);
  assign down    = ({1'b0, pos} == {1'b0, idx} + ONE_P);
  assign jump    = any_set && !multi_set && (state != IDLE) && !same && !up && !down;
  assign err_set = multi_set || jump;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1        <= '0;
      sample       <= '0;
      state        <= IDLE;
      pos          <= '0;
      pos_valid    <= 1'b0;
      dir          <= 1'b1;
      dir_known    <= 1'b0;
      step         <= 1'b0;
      bounce       <= 1'b0;
      bounce_count <= '0;
      err          <= 1'b0;
      gap          <= '0;
    end else begin
      sync1  <= leds_in;
      sample <= sync1;
      step   <= 1'b0;
      bounce <= 1'b0;
      err    <= err_set | (err & ~err_clr);

      if (!multi_set) begin
        if (any_set) begin
          if (state == IDLE) begin
            pos       <= idx;
            pos_valid <= 1'b1;
            dir_known <= 1'b0;
          end else if (up || down) begin
            pos       <= idx;
            step      <= 1'b1;
            dir       <= up;
            dir_known <= 1'b1;
            if (dir_known && (up != dir)) begin
              bounce <= 1'b1;
              if (bounce_count != '1) bounce_count <= bounce_count + ONE_C;
            end
          end else if (!same) begin
            pos       <= idx;
            dir_known <= 1'b0;
          end
          state <= TRACK;
          gap   <= '0;
        end else begin
          case (state)
            TRACK: begin
              gap <= ONE_G;
              if (HOLD_CYCLES == 1) begin
                pos_valid <= 1'b0;
                state     <= IDLE;
              end else begin
                state <= DARK;
              end
            end
            DARK: begin
              gap <= gap + ONE_G;
              // Position is only abandoned after a full run of dark samples.
              if (gap == GAP_LAST) begin
                pos_valid <= 1'b0;
                state     <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_position_decoder.sv
// Scoreboard bench for led_position_decoder: expected step events are queued by the
// stimulus and popped by a monitor on each step pulse; level outputs are checked directly.
module tb_led_position_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] leds_in;
  logic       err_clr;

  logic [2:0] pos;
  logic       pos_valid, dir, step, bounce, err;
  logic [7:0] bounce_count;
  logic [1:0] fsm_state;

  logic [2:0] sat_pos;
  logic       sat_pos_valid, sat_dir, sat_step, sat_bounce, sat_err;
  logic [1:0] sat_bounce_count;
  logic [1:0] sat_fsm_state;

  int checks = 0;
  int passes = 0;
  int sat_bounces = 0;

  // Event record: {pos, dir, bounce, bounce_count}
  logic [12:0] exp_q[$];
  logic [12:0] got_ev, exp_ev;

  always #5 clk = ~clk;

  led_position_decoder u_dut (
    .clk(clk), .reset_n(reset_n), .leds_in(leds_in), .err_clr(err_clr),
    .pos(pos), .pos_valid(pos_valid), .dir(dir), .step(step), .bounce(bounce),
    .bounce_count(bounce_count), .err(err), .fsm_state(fsm_state)
  );

  led_position_decoder #(.CNT_WIDTH(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .leds_in(leds_in), .err_clr(err_clr),
    .pos(sat_pos), .pos_valid(sat_pos_valid), .dir(sat_dir), .step(sat_step),
    .bounce(sat_bounce), .bounce_count(sat_bounce_count), .err(sat_err),
    .fsm_state(sat_fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [12:0] ev(input logic [2:0] p, input logic d, input logic b,
                                     input logic [7:0] c);
    return {p, d, b, c};
  endfunction

  task automatic hold(input logic [7:0] v, input int n);
    leds_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && step) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_step: got pos=%0d dir=%0d required no step", pos, dir);
      end else begin
        got_ev = {pos, dir, bounce, bounce_count};
        exp_ev = exp_q.pop_front();
        check("step_event", 32'(got_ev), 32'(exp_ev));
      end
    end
    if (reset_n && sat_bounce) sat_bounces++;
  end

  initial begin
    int cnt;
    logic b;

    reset_n = 1'b0;
    leds_in = 8'h00;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pos", 32'(pos), 0);
    check("rst_pos_valid", 32'(pos_valid), 0);
    check("rst_dir", 32'(dir), 1);
    check("rst_count", 32'(bounce_count), 0);
    check("rst_err", 32'(err), 0);
    reset_n = 1'b1;

    // Upward sweep, then reversal at the MSB end.
    hold(8'h01, 10);
    check("acquire_valid", 32'(pos_valid), 1);
    check("acquire_pos", 32'(pos), 0);
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(ev(3'(i), 1'b1, 1'b0, 8'd0));
      hold(8'(1 << i), 10);
    end
    exp_q.push_back(ev(3'd6, 1'b0, 1'b1, 8'd1));
    hold(8'h40, 10);
    check("bounce_dir", 32'(dir), 0);
    check("bounce_count_1", 32'(bounce_count), 1);

    // Walk down to 3, then PWM gaps shorter than the hold window.
    for (int i = 5; i >= 3; i--) begin
      exp_q.push_back(ev(3'(i), 1'b0, 1'b0, 8'd1));
      hold(8'(1 << i), 10);
    end
    for (int r = 0; r < 3; r++) begin
      hold(8'h00, 4);
      hold(8'h08, 6);
    end
    check("gap_pos", 32'(pos), 3);
    check("gap_valid", 32'(pos_valid), 1);

    // Long dark run: 16th sampled zero lands on the 18th edge after the change.
    leds_in = 8'h00;
    repeat (17) @(posedge clk);
    #1;
    check("dark_valid_before", 32'(pos_valid), 1);
    @(posedge clk);
    #1;
    check("dark_valid_drop", 32'(pos_valid), 0);
    check("dark_pos_kept", 32'(pos), 3);
    hold(8'h00, 2);

    // Reacquire: first move after IDLE never bounces, the next reversal does.
    hold(8'h08, 10);
    check("reacquire_valid", 32'(pos_valid), 1);
    exp_q.push_back(ev(3'd4, 1'b1, 1'b0, 8'd1));
    hold(8'h10, 10);
    exp_q.push_back(ev(3'd3, 1'b0, 1'b1, 8'd2));
    hold(8'h08, 10);

    // Protocol errors.
    hold(8'h18, 10);
    check("multi_err", 32'(err), 1);
    check("multi_pos", 32'(pos), 3);
    hold(8'h01, 10);
    check("jump_err", 32'(err), 1);
    check("jump_pos", 32'(pos), 0);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clear", 32'(err), 0);
    leds_in = 8'h03;
    repeat (2) @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clr_vs_multi", 32'(err), 1);
    hold(8'h01, 10);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("err_clear_again", 32'(err), 0);

    // Five full back-and-forth sweeps from pos 0 (direction unknown after the jump).
    cnt = 2;
    for (int r = 0; r < 5; r++) begin
      for (int i = 1; i < 8; i++) begin
        b = (i == 1) && (r > 0);
        if (b) cnt++;
        exp_q.push_back(ev(3'(i), 1'b1, b, 8'(cnt)));
        hold(8'(1 << i), 4);
      end
      for (int i = 6; i >= 0; i--) begin
        b = (i == 6);
        if (b) cnt++;
        exp_q.push_back(ev(3'(i), 1'b0, b, 8'(cnt)));
        hold(8'(1 << i), 4);
      end
    end
    hold(8'h01, 4);
    check("sweep_count", 32'(bounce_count), 11);
    check("sat_count", 32'(sat_bounce_count), 3);
    check("sat_pulses", 32'(sat_bounces), 11);

    // Latency: change just after edge k, step visible only after edge k+3.
    exp_q.push_back(ev(3'd1, 1'b1, 1'b1, 8'd12));
    leds_in = 8'h02;
    @(posedge clk);
    #1;
    check("lat_k1", 32'(step), 0);
    @(posedge clk);
    #1;
    check("lat_k2", 32'(step), 0);
    @(posedge clk);
    #1;
    check("lat_k3", 32'(step), 1);
    @(posedge clk);
    #1;
    check("lat_k4", 32'(step), 0);
    hold(8'h02, 6);

    // Asynchronous reset in mid-cycle, no clock edge in between.
    hold(8'h08, 10);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_pos", 32'(pos), 0);
    check("async_valid", 32'(pos_valid), 0);
    check("async_dir", 32'(dir), 1);
    check("async_count", 32'(bounce_count), 0);
    check("async_err", 32'(err), 0);
    repeat (2) @(posedge clk);
    #1;

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
